// File: rtl/bp_axi_dram_window_if.sv
// AXI4 bundle (AXI3-style 4-bit len and 2-bit lock) shared by the upstream and downstream sides of the DRAM window.
// The master modport drives AW/W/AR and the response readies; the slave modport drives the rest.
interface bp_axi_dram_window_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 64,
    parameter int id_width_p   = 6
) ();
    logic [addr_width_p-1:0]   awaddr;
    logic [id_width_p-1:0]     awid;
    logic [3:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic [1:0]                awlock;
    logic [3:0]                awqos;
    logic                      awvalid;
    logic                      awready;

    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [id_width_p-1:0]     bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [addr_width_p-1:0]   araddr;
    logic [id_width_p-1:0]     arid;
    logic [3:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic [1:0]                arlock;
    logic [3:0]                arqos;
    logic                      arvalid;
    logic                      arready;

    logic [data_width_p-1:0]   rdata;
    logic [id_width_p-1:0]     rid;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awid, awlen, awsize, awburst, awcache, awprot, awlock, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output araddr, arid, arlen, arsize, arburst, arcache, arprot, arlock, arqos, arvalid,
        input  arready,
        input  rdata, rid, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awid, awlen, awsize, awburst, awcache, awprot, awlock, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  araddr, arid, arlen, arsize, arburst, arcache, arprot, arlock, arqos, arvalid,
        output arready,
        output rdata, rid, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/bp_axi_dram_window.sv
// DRAM window filter between the L2 DMA AXI master and the HP port: rebases in-window bursts,
// caps outstanding traffic, and answers out-of-window bursts locally with DECERR.
module bp_axi_dram_window #(
    parameter int                          axi_addr_width_p  = 32,
    parameter int                          axi_data_width_p  = 64,
    parameter int                          axi_id_width_p    = 6,
    parameter logic [axi_addr_width_p-1:0] win_base_p        = 32'h8000_0000,
    parameter logic [axi_addr_width_p-1:0] win_size_p        = 32'h1000_0000,
    parameter logic [axi_addr_width_p-1:0] phys_base_p       = 32'h1000_0000,
    parameter int                          max_outstanding_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bp_axi_dram_window_if.slave     s_axi,
    bp_axi_dram_window_if.master    m_axi,
    output logic [15:0]             err_count_o
);
    localparam int aw_lp = axi_addr_width_p;
    localparam int cw_lp = $clog2(max_outstanding_p + 1);
    localparam logic [cw_lp-1:0] max_lp = cw_lp'(max_outstanding_p);
    localparam logic [aw_lp:0] win_lo_lp = {1'b0, win_base_p};
    localparam logic [aw_lp:0] win_hi_lp = {1'b0, win_base_p} + {1'b0, win_size_p};

    typedef enum logic [2:0] {W_IDLE, W_FWD, W_DRAIN, W_ERRW, W_ERRB} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_ERR} r_state_e;

    // Last byte is computed one bit wider so bursts wrapping past 2^A are rejected.
    function automatic logic in_window(input logic [aw_lp-1:0] addr, input logic [3:0] len,
                                       input logic [2:0] size);
        logic [aw_lp:0] bytes;
        logic [aw_lp:0] last;
        bytes = ({{(aw_lp-3){1'b0}}, len} + (aw_lp+1)'(1)) << size;
        last  = {1'b0, addr} + bytes - (aw_lp+1)'(1);
        return ({1'b0, addr} >= win_lo_lp) && (last < win_hi_lp);
    endfunction

    w_state_e                   w_state_reg, w_state_next;
    r_state_e                   r_state_reg, r_state_next;
    logic [cw_lp-1:0]           wr_out_reg, rd_out_reg;
    logic [axi_id_width_p-1:0]  awid_reg, awid_next;
    logic [axi_id_width_p-1:0]  arid_reg, arid_next;
    logic [3:0]                 arlen_reg, arlen_next;
    logic [3:0]                 beat_reg, beat_next;
    logic [15:0]                err_count_reg;
    logic [16:0]                err_sum;

    logic aw_in_win, ar_in_win;
    logic wr_inc, wr_dec, rd_inc, rd_dec;
    logic wr_room, rd_room;
    logic err_w, err_r;

    assign aw_in_win = in_window(s_axi.awaddr, s_axi.awlen, s_axi.awsize);
    assign ar_in_win = in_window(s_axi.araddr, s_axi.arlen, s_axi.arsize);

    // Retirements are derived from inputs so the room check has no path through our own readies.
    assign wr_dec  = m_axi.bvalid && s_axi.bready && (w_state_reg != W_ERRB) && reset_n_i;
    assign rd_dec  = m_axi.rvalid && s_axi.rready && m_axi.rlast && (r_state_reg != R_ERR) && reset_n_i;
    assign wr_room = (wr_out_reg < max_lp) || wr_dec;
    assign rd_room = (rd_out_reg < max_lp) || rd_dec;

    assign m_axi.awaddr  = s_axi.awaddr - win_base_p + phys_base_p;
    assign m_axi.awid    = s_axi.awid;
    assign m_axi.awlen   = s_axi.awlen;
    assign m_axi.awsize  = s_axi.awsize;
    assign m_axi.awburst = s_axi.awburst;
    assign m_axi.awcache = s_axi.awcache;
    assign m_axi.awprot  = s_axi.awprot;
    assign m_axi.awlock  = s_axi.awlock;
    assign m_axi.awqos   = s_axi.awqos;
    assign m_axi.wdata   = s_axi.wdata;
    assign m_axi.wstrb   = s_axi.wstrb;
    assign m_axi.wlast   = s_axi.wlast;
    assign m_axi.araddr  = s_axi.araddr - win_base_p + phys_base_p;
    assign m_axi.arid    = s_axi.arid;
    assign m_axi.arlen   = s_axi.arlen;
    assign m_axi.arsize  = s_axi.arsize;
    assign m_axi.arburst = s_axi.arburst;
    assign m_axi.arcache = s_axi.arcache;
    assign m_axi.arprot  = s_axi.arprot;
    assign m_axi.arlock  = s_axi.arlock;
    assign m_axi.arqos   = s_axi.arqos;

    always_comb begin
        w_state_next  = w_state_reg;
        awid_next     = awid_reg;
        wr_inc        = 1'b0;
        err_w         = 1'b0;
        s_axi.awready = 1'b0;
        m_axi.awvalid = 1'b0;
        s_axi.wready  = 1'b0;
        m_axi.wvalid  = 1'b0;
        s_axi.bvalid  = m_axi.bvalid;
        s_axi.bid     = m_axi.bid;
        s_axi.bresp   = m_axi.bresp;
        m_axi.bready  = s_axi.bready;
        case (w_state_reg)
            W_IDLE: begin
                if (s_axi.awvalid) begin
                    if (!aw_in_win) begin
                        w_state_next = W_DRAIN;
                    end else if (wr_room) begin
                        m_axi.awvalid = 1'b1;
                        s_axi.awready = m_axi.awready;
                        if (m_axi.awready) begin
                            wr_inc       = 1'b1;
                            w_state_next = W_FWD;
                        end
                    end
                end
            end
            W_DRAIN: begin
                if (wr_out_reg == '0) begin
                    s_axi.awready = 1'b1;
                    if (s_axi.awvalid) begin
                        awid_next    = s_axi.awid;
                        w_state_next = W_ERRW;
                    end
                end
            end
            W_FWD: begin
                m_axi.wvalid = s_axi.wvalid;
                s_axi.wready = m_axi.wready;
                if (s_axi.wvalid && m_axi.wready && s_axi.wlast) begin
                    w_state_next = W_IDLE;
                end
            end
            W_ERRW: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid && s_axi.wlast) begin
                    w_state_next = W_ERRB;
                end
            end
            W_ERRB: begin
                s_axi.bvalid = 1'b1;
                s_axi.bid    = awid_reg;
                s_axi.bresp  = 2'b11;
                m_axi.bready = 1'b0;
                if (s_axi.bready) begin
                    err_w        = 1'b1;
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
        if (!reset_n_i) begin
            s_axi.awready = 1'b0;
            m_axi.awvalid = 1'b0;
            s_axi.wready  = 1'b0;
            m_axi.wvalid  = 1'b0;
            s_axi.bvalid  = 1'b0;
            m_axi.bready  = 1'b0;
        end
    end

    always_comb begin
        r_state_next  = r_state_reg;
        arid_next     = arid_reg;
        arlen_next    = arlen_reg;
        beat_next     = beat_reg;
        rd_inc        = 1'b0;
        err_r         = 1'b0;
        s_axi.arready = 1'b0;
        m_axi.arvalid = 1'b0;
        s_axi.rvalid  = m_axi.rvalid;
        s_axi.rdata   = m_axi.rdata;
        s_axi.rid     = m_axi.rid;
        s_axi.rresp   = m_axi.rresp;
        s_axi.rlast   = m_axi.rlast;
        m_axi.rready  = s_axi.rready;
        case (r_state_reg)
            R_IDLE: begin
                if (s_axi.arvalid) begin
                    if (!ar_in_win) begin
                        r_state_next = R_DRAIN;
                    end else if (rd_room) begin
                        m_axi.arvalid = 1'b1;
                        s_axi.arready = m_axi.arready;
                        rd_inc        = m_axi.arready;
                    end
                end
            end
            R_DRAIN: begin
                if (rd_out_reg == '0) begin
                    s_axi.arready = 1'b1;
                    if (s_axi.arvalid) begin
                        arid_next    = s_axi.arid;
                        arlen_next   = s_axi.arlen;
                        beat_next    = 4'd0;
                        r_state_next = R_ERR;
                    end
                end
            end
            R_ERR: begin
                s_axi.rvalid = 1'b1;
                s_axi.rdata  = '0;
                s_axi.rid    = arid_reg;
                s_axi.rresp  = 2'b11;
                s_axi.rlast  = (beat_reg == arlen_reg);
                m_axi.rready = 1'b0;
                if (s_axi.rready) begin
                    if (beat_reg == arlen_reg) begin
                        err_r        = 1'b1;
                        r_state_next = R_IDLE;
                    end else begin
                        beat_next = beat_reg + 4'd1;
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
        if (!reset_n_i) begin
            s_axi.arready = 1'b0;
            m_axi.arvalid = 1'b0;
            s_axi.rvalid  = 1'b0;
            m_axi.rready  = 1'b0;
        end
    end

    assign err_sum     = {1'b0, err_count_reg} + {16'd0, err_w} + {16'd0, err_r};
    assign err_count_o = err_count_reg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_state_reg   <= W_IDLE;
            r_state_reg   <= R_IDLE;
            wr_out_reg    <= '0;
            rd_out_reg    <= '0;
            awid_reg      <= '0;
            arid_reg      <= '0;
            arlen_reg     <= '0;
            beat_reg      <= '0;
            err_count_reg <= '0;
        end else begin
            w_state_reg   <= w_state_next;
            r_state_reg   <= r_state_next;
            awid_reg      <= awid_next;
            arid_reg      <= arid_next;
            arlen_reg     <= arlen_next;
            beat_reg      <= beat_next;
            err_count_reg <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            case ({wr_inc, wr_dec})
                2'b10:   wr_out_reg <= wr_out_reg + 1'b1;
                2'b01:   wr_out_reg <= wr_out_reg - 1'b1;
                default: wr_out_reg <= wr_out_reg;
            endcase
            case ({rd_inc, rd_dec})
                2'b10:   rd_out_reg <= rd_out_reg + 1'b1;
                2'b01:   rd_out_reg <= rd_out_reg - 1'b1;
                default: rd_out_reg <= rd_out_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_bp_axi_dram_window.sv
// Directed bench for bp_axi_dram_window: a read-vector table plus hand-written write,
// outstanding-cap, drain and mid-burst reset sequences.
module tb_bp_axi_dram_window;
    logic        clk;
    logic        rst_n;
    logic [15:0] err_count;
    int          total;
    int          bad;
    int          exp_err;

    bp_axi_dram_window_if #(.addr_width_p(32), .data_width_p(64), .id_width_p(6)) s_if ();
    bp_axi_dram_window_if #(.addr_width_p(32), .data_width_p(64), .id_width_p(6)) m_if ();

    bp_axi_dram_window dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .s_axi      (s_if),
        .m_axi      (m_if),
        .err_count_o(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        bit          in_win;
        logic [31:0] maddr;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_arready(input string name);
        int n = 0;
        while (s_if.arready !== 1'b1 && n < 20) begin
            next_cycle();
            #1;
            n++;
        end
        chk(name, 64'(s_if.arready), 64'(1));
    endtask

    // Starts on a negedge; returns on a negedge with no burst outstanding.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input bit in_win, input logic [31:0] maddr, input logic [5:0] id);
        logic [63:0] exp_d;
        s_if.araddr  = addr;
        s_if.arlen   = len;
        s_if.arsize  = size;
        s_if.arburst = 2'b01;
        s_if.arid    = id;
        s_if.arvalid = 1'b1;
        m_if.arready = 1'b1;
        #1;
        if (in_win) begin
            chk("ar_fwd_valid", 64'(m_if.arvalid), 64'(1));
            chk("ar_rebased", 64'(m_if.araddr), 64'(maddr));
            chk("ar_fwd_id", 64'(m_if.arid), 64'(id));
            chk("ar_ready", 64'(s_if.arready), 64'(1));
            next_cycle();
            s_if.arvalid = 1'b0;
            s_if.rready  = 1'b1;
            for (int k = 0; k <= int'(len); k++) begin
                exp_d        = {32'hA5A5_0000, addr} + 64'(k);
                m_if.rvalid  = 1'b1;
                m_if.rdata   = exp_d;
                m_if.rid     = id;
                m_if.rresp   = 2'b00;
                m_if.rlast   = (k == int'(len));
                #1;
                chk("r_pass_valid", 64'(s_if.rvalid), 64'(1));
                chk("r_pass_data", s_if.rdata, exp_d);
                chk("r_pass_last", 64'(s_if.rlast), 64'(k == int'(len)));
                next_cycle();
            end
            m_if.rvalid = 1'b0;
            m_if.rlast  = 1'b0;
        end else begin
            chk("ar_oow_blocked", 64'(s_if.arready), 64'(0));
            chk("ar_oow_no_fwd", 64'(m_if.arvalid), 64'(0));
            wait_arready("ar_oow_accept");
            chk("ar_oow_no_fwd2", 64'(m_if.arvalid), 64'(0));
            next_cycle();
            s_if.arvalid = 1'b0;
            s_if.rready  = 1'b1;
            for (int k = 0; k <= int'(len); k++) begin
                #1;
                chk("rerr_valid", 64'(s_if.rvalid), 64'(1));
                chk("rerr_resp", 64'(s_if.rresp), 64'(3));
                chk("rerr_data", s_if.rdata, 64'(0));
                chk("rerr_id", 64'(s_if.rid), 64'(id));
                chk("rerr_last", 64'(s_if.rlast), 64'(k == int'(len)));
                next_cycle();
            end
            #1;
            exp_err++;
            chk("rerr_done", 64'(s_if.rvalid), 64'(0));
            chk("err_count_rd", 64'(err_count), 64'(exp_err));
        end
        s_if.rready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0; exp_err = 0;
        rst_n = 1'b0;
        {s_if.awaddr, s_if.awid, s_if.awlen, s_if.awsize, s_if.awburst, s_if.awcache} = '0;
        {s_if.awprot, s_if.awlock, s_if.awqos, s_if.awvalid} = '0;
        {s_if.wdata, s_if.wstrb, s_if.wlast, s_if.wvalid, s_if.bready} = '0;
        {s_if.araddr, s_if.arid, s_if.arlen, s_if.arsize, s_if.arburst, s_if.arcache} = '0;
        {s_if.arprot, s_if.arlock, s_if.arqos, s_if.arvalid, s_if.rready} = '0;
        {m_if.awready, m_if.wready, m_if.bid, m_if.bresp, m_if.bvalid, m_if.arready} = '0;
        {m_if.rdata, m_if.rid, m_if.rresp, m_if.rlast, m_if.rvalid} = '0;

        vecs[0] = '{32'h8000_0040, 4'd7,  3'd3, 1'b1, 32'h1000_0040};
        vecs[1] = '{32'h8000_0000, 4'd0,  3'd0, 1'b1, 32'h1000_0000};
        vecs[2] = '{32'h8FFF_FFC0, 4'd7,  3'd3, 1'b1, 32'h1FFF_FFC0};
        vecs[3] = '{32'h8FFF_FFF8, 4'd1,  3'd3, 1'b0, 32'h0};
        vecs[4] = '{32'h7FFF_FFFC, 4'd0,  3'd2, 1'b0, 32'h0};
        vecs[5] = '{32'h0000_1000, 4'd3,  3'd3, 1'b0, 32'h0};
        vecs[6] = '{32'hFFFF_FFF0, 4'd15, 3'd3, 1'b0, 32'h0};
        vecs[7] = '{32'h8800_0000, 4'd15, 3'd2, 1'b1, 32'h1800_0000};

        // Outputs held quiet while in reset even with traffic presented.
        @(negedge clk);
        s_if.araddr = 32'h8000_0000; s_if.arvalid = 1'b1; m_if.arready = 1'b1;
        m_if.rvalid = 1'b1; s_if.rready = 1'b1;
        #1;
        chk("rst_arready", 64'(s_if.arready), 64'(0));
        chk("rst_m_arvalid", 64'(m_if.arvalid), 64'(0));
        chk("rst_rvalid", 64'(s_if.rvalid), 64'(0));
        chk("rst_err_count", 64'(err_count), 64'(0));
        s_if.arvalid = 1'b0; m_if.rvalid = 1'b0; s_if.rready = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        $display("reset check done");

        for (int i = 0; i < 8; i++) begin
            do_read(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].in_win, vecs[i].maddr, 6'(i + 1));
            $display("read vec %0d addr=%h len=%0d size=%0d in_win=%0d err_count=%0d",
                     i, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].in_win, err_count);
        end

        // In-window write: AW, 2 W beats and B pass straight through.
        s_if.awaddr = 32'h8000_0100; s_if.awlen = 4'd1; s_if.awsize = 3'd3; s_if.awid = 6'd3;
        s_if.awvalid = 1'b1; m_if.awready = 1'b1;
        #1;
        chk("aw_fwd_valid", 64'(m_if.awvalid), 64'(1));
        chk("aw_rebased", 64'(m_if.awaddr), 64'h1000_0100);
        chk("aw_ready", 64'(s_if.awready), 64'(1));
        next_cycle();
        s_if.awvalid = 1'b0; m_if.wready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_if.wdata = 64'h1234_0000 + 64'(k); s_if.wvalid = 1'b1; s_if.wlast = (k == 1);
            #1;
            chk("w_fwd_valid", 64'(m_if.wvalid), 64'(1));
            chk("w_fwd_data", m_if.wdata, 64'h1234_0000 + 64'(k));
            chk("w_fwd_ready", 64'(s_if.wready), 64'(1));
            next_cycle();
        end
        s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
        m_if.bvalid = 1'b1; m_if.bid = 6'd3; m_if.bresp = 2'b00; s_if.bready = 1'b1;
        #1;
        chk("b_fwd_valid", 64'(s_if.bvalid), 64'(1));
        chk("b_fwd_id", 64'(s_if.bid), 64'(3));
        chk("b_fwd_resp", 64'(s_if.bresp), 64'(0));
        next_cycle();
        m_if.bvalid = 1'b0; s_if.bready = 1'b0;
        $display("write fwd addr=80000100 len=1 done");

        // Out-of-window write: answered locally with DECERR.
        s_if.awaddr = 32'h0000_1000; s_if.awlen = 4'd3; s_if.awid = 6'd5; s_if.awvalid = 1'b1;
        #1;
        chk("aw_oow_blocked", 64'(s_if.awready), 64'(0));
        chk("aw_oow_no_fwd", 64'(m_if.awvalid), 64'(0));
        begin
            int n = 0;
            while (s_if.awready !== 1'b1 && n < 20) begin
                next_cycle(); #1; n++;
            end
        end
        chk("aw_oow_accept", 64'(s_if.awready), 64'(1));
        next_cycle();
        s_if.awvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_if.wvalid = 1'b1; s_if.wlast = (k == 3); s_if.wdata = 64'(k);
            #1;
            chk("werr_ready", 64'(s_if.wready), 64'(1));
            chk("werr_no_fwd", 64'(m_if.wvalid), 64'(0));
            next_cycle();
        end
        s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
        #1;
        chk("berr_valid", 64'(s_if.bvalid), 64'(1));
        chk("berr_id", 64'(s_if.bid), 64'(5));
        chk("berr_resp", 64'(s_if.bresp), 64'(3));
        next_cycle();
        #1;
        chk("berr_held", 64'(s_if.bvalid), 64'(1));
        s_if.bready = 1'b1;
        next_cycle();
        s_if.bready = 1'b0;
        #1;
        exp_err++;
        chk("berr_done", 64'(s_if.bvalid), 64'(0));
        chk("err_count_wr", 64'(err_count), 64'(exp_err));
        $display("write oow addr=00001000 len=3 err_count=%0d", err_count);

        // Outstanding cap: 4 accepted, 5th waits, then enters on the same cycle as a retire.
        @(negedge clk);
        m_if.arready = 1'b1; s_if.arlen = 4'd0; s_if.arsize = 3'd3;
        for (int i = 0; i < 4; i++) begin
            s_if.araddr = 32'h8000_0000 + 32'(i * 256); s_if.arid = 6'(i); s_if.arvalid = 1'b1;
            #1;
            chk("cap_accept", 64'(s_if.arready), 64'(1));
            next_cycle();
        end
        s_if.araddr = 32'h8000_0400; s_if.arid = 6'd4;
        #1;
        chk("cap_5th_blocked", 64'(s_if.arready), 64'(0));
        chk("cap_5th_no_fwd", 64'(m_if.arvalid), 64'(0));
        next_cycle();
        m_if.rvalid = 1'b1; m_if.rlast = 1'b1; m_if.rid = 6'd0; s_if.rready = 1'b1;
        #1;
        chk("cap_5th_on_retire", 64'(s_if.arready), 64'(1));
        chk("cap_5th_fwd", 64'(m_if.arvalid), 64'(1));
        next_cycle();
        m_if.rvalid = 1'b0; s_if.araddr = 32'h8000_0500;
        #1;
        chk("cap_still_full", 64'(s_if.arready), 64'(0));
        s_if.arvalid = 1'b0;
        next_cycle();
        m_if.rvalid = 1'b1;
        repeat (4) next_cycle();
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s_if.rready = 1'b0;
        $display("outstanding cap sequence done");

        // Drain: out-of-window AR waits for both outstanding R-lasts.
        for (int i = 0; i < 2; i++) begin
            s_if.araddr = 32'h8000_1000 + 32'(i * 64); s_if.arvalid = 1'b1;
            #1;
            chk("drain_pre_accept", 64'(s_if.arready), 64'(1));
            next_cycle();
        end
        s_if.araddr = 32'h0000_2000; s_if.arlen = 4'd1; s_if.arid = 6'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain_wait", 64'(s_if.arready), 64'(0));
            next_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            m_if.rvalid = 1'b1; m_if.rlast = 1'b1; s_if.rready = 1'b1;
            #1;
            chk("drain_retiring", 64'(s_if.arready), 64'(0));
            next_cycle();
        end
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s_if.rready = 1'b0;
        #1;
        chk("drain_accept", 64'(s_if.arready), 64'(1));
        next_cycle();
        s_if.arvalid = 1'b0; s_if.rready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("drain_rerr_valid", 64'(s_if.rvalid), 64'(1));
            chk("drain_rerr_last", 64'(s_if.rlast), 64'(k == 1));
            next_cycle();
        end
        s_if.rready = 1'b0;
        #1;
        exp_err++;
        chk("drain_err_count", 64'(err_count), 64'(exp_err));
        $display("drain sequence done err_count=%0d", err_count);

        // Reset asserted during beat 2 of a 4-beat error burst.
        @(negedge clk);
        s_if.araddr = 32'h0000_3000; s_if.arlen = 4'd3; s_if.arid = 6'd7; s_if.arvalid = 1'b1;
        #1;
        wait_arready("rst_seq_accept");
        next_cycle();
        s_if.arvalid = 1'b0; s_if.rready = 1'b1;
        next_cycle();
        #1;
        chk("rst_seq_beat2", 64'(s_if.rvalid), 64'(1));
        chk("rst_seq_beat2_last", 64'(s_if.rlast), 64'(0));
        s_if.araddr = 32'h8000_0000; s_if.arlen = 4'd0; s_if.arvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", 64'(s_if.rvalid), 64'(0));
        chk("rst_mid_m_arvalid", 64'(m_if.arvalid), 64'(0));
        chk("rst_mid_err_count", 64'(err_count), 64'(0));
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("rst_release_accept", 64'(s_if.arready), 64'(1));
        chk("rst_release_fwd", 64'(m_if.arvalid), 64'(1));
        next_cycle();
        s_if.arvalid = 1'b0; s_if.rready = 1'b0;
        $display("mid-burst reset sequence done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
